// File: rtl/logic_sel_fifo.sv
// logic_sel_fifo
//   Computes mux / AND / OR / XOR over NUM_IN operands of WIDTH bits, with
//   optional inversion, and queues each result in a DEPTH-entry FIFO.
//
// Ports
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready              request handshake (in_ready is registered)
//   in_data                        operand k at [k*WIDTH +: WIDTH]
//   in_sel                         operand index for mux mode (>= NUM_IN gives 0)
//   in_mode                        0=mux 1=AND 2=OR 3=XOR
//   in_inv                         invert the result before queueing
//   out_valid/out_ready/out_data   FIFO head handshake and data
//   level                          occupancy 0..DEPTH
//   acc_cnt                        accepted requests, saturating
//   rej_cnt                        refused request cycles, saturating
//
// Build option
//   LSF_REJ_CNT_EN  when defined, rej_cnt counts in_valid & !in_ready cycles;
//                   otherwise rej_cnt is tied to 0.
module logic_sel_fifo #(
    parameter  int unsigned WIDTH  = 1,
    parameter  int unsigned NUM_IN = 4,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned CNT_W  = 8,
    localparam int unsigned SEL_W  = $clog2(NUM_IN),
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned LVL_W  = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [1:0]              in_mode,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [LVL_W-1:0]        level,
    output logic [CNT_W-1:0]        acc_cnt,
    output logic [CNT_W-1:0]        rej_cnt
);

    typedef enum logic [1:0] {
        MODE_MUX = 2'd0,
        MODE_AND = 2'd1,
        MODE_OR  = 2'd2,
        MODE_XOR = 2'd3
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] op_mux, op_and, op_or, op_xor;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             push, pop;

    assign mode = mode_e'(in_mode);

    // Mux select is matched against every index so an out-of-range in_sel
    // naturally leaves op_mux at 0.
    always_comb begin
        op_mux = '0;
        op_and = '1;
        op_or  = '0;
        op_xor = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            op_and = op_and & in_data[k*WIDTH +: WIDTH];
            op_or  = op_or  | in_data[k*WIDTH +: WIDTH];
            op_xor = op_xor ^ in_data[k*WIDTH +: WIDTH];
            if (32'(in_sel) == k) begin
                op_mux = in_data[k*WIDTH +: WIDTH];
            end
        end
        case (mode)
            MODE_MUX: result = op_mux;
            MODE_AND: result = op_and;
            MODE_OR:  result = op_or;
            default:  result = op_xor;
        endcase
        if (in_inv) begin
            result = ~result;
        end
    end

    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        acc_cnt_d = acc_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            if (acc_cnt_q != '1) begin
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // in_ready is registered from the next level so it never depends
        // combinationally on out_ready; a pop at full reopens it next cycle.
        in_ready_d = (level_d != LVL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b1;
            acc_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    // Storage needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready = in_ready_q;
    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign acc_cnt  = acc_cnt_q;

`ifdef LSF_REJ_CNT_EN
    logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;

    always_comb begin
        rej_cnt_d = rej_cnt_q;
        if (in_valid && !in_ready_q && (rej_cnt_q != '1)) begin
            rej_cnt_d = rej_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt_q <= '0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
        end
    end

    assign rej_cnt = rej_cnt_q;
`else
    assign rej_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_sel_fifo.sv
// Testbench for logic_sel_fifo: default instance (WIDTH=1, NUM_IN=4,
// DEPTH=4, CNT_W=8) plus a NUM_IN=3, WIDTH=2, CNT_W=2 instance for the
// out-of-range select and counter saturation cases.
module tb_logic_sel_fifo;

    logic clk;
    logic rst;

    // default instance
    logic       in_valid, in_ready, in_inv, out_valid, out_ready, out_data;
    logic [3:0] in_data;
    logic [1:0] in_sel, in_mode;
    logic [2:0] level;
    logic [7:0] acc_cnt, rej_cnt;

    // 3-operand instance
    logic       in_valid3, in_ready3, in_inv3, out_valid3, out_ready3;
    logic [5:0] in_data3;
    logic [1:0] in_sel3, in_mode3, out_data3;
    logic [2:0] level3;
    logic [1:0] acc_cnt3, rej_cnt3;

    logic       exp_cur;
    logic [1:0] exp_cur3;
    logic       sb[$];
    logic [1:0] sb3[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] vd [12];
    logic [1:0] vs [12];
    logic [1:0] vm [12];
    logic       vi [12];
    logic       ve [12];

    logic_sel_fifo u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_mode(in_mode), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
    );

    logic_sel_fifo #(.WIDTH(2), .NUM_IN(3), .DEPTH(4), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .in_sel(in_sel3), .in_mode(in_mode3), .in_inv(in_inv3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .level(level3), .acc_cnt(acc_cnt3), .rej_cnt(rej_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] d, input logic [1:0] s,
                         input logic [1:0] m, input logic inv, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_mode  = m;
        in_inv   = inv;
        exp_cur  = e;
    endtask

    task automatic issue3(input logic [5:0] d, input logic [1:0] s,
                          input logic [1:0] m, input logic inv, input logic [1:0] e);
        in_valid3 = 1'b1;
        in_data3  = d;
        in_sel3   = s;
        in_mode3  = m;
        in_inv3   = inv;
        exp_cur3  = e;
    endtask

    // scoreboard: record accepted requests, check every popped result
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) sb.push_back(exp_cur);
        if (!rst && in_valid3 && in_ready3) sb3.push_back(exp_cur3);
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else chk("out_data", int'(out_data), int'(sb.pop_front()));
        end
        if (!rst && out_valid3 && out_ready3) begin
            if (sb3.size() == 0) chk("unexpected_out3", 1, 0);
            else chk("out_data3", int'(out_data3), int'(sb3.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_rej;
        // {d,c,b,a}; a is bit 0. Modes: 0 mux, 1 AND, 2 OR, 3 XOR.
        vd[0]  = 4'b0001; vs[0]  = 2'd0; vm[0]  = 2'd1; vi[0]  = 1'b0; ve[0]  = 1'b0;
        vd[1]  = 4'b1111; vs[1]  = 2'd0; vm[1]  = 2'd1; vi[1]  = 1'b0; ve[1]  = 1'b1;
        vd[2]  = 4'b0000; vs[2]  = 2'd0; vm[2]  = 2'd2; vi[2]  = 1'b0; ve[2]  = 1'b0;
        vd[3]  = 4'b0100; vs[3]  = 2'd0; vm[3]  = 2'd2; vi[3]  = 1'b0; ve[3]  = 1'b1;
        vd[4]  = 4'b0111; vs[4]  = 2'd0; vm[4]  = 2'd3; vi[4]  = 1'b0; ve[4]  = 1'b1;
        vd[5]  = 4'b0011; vs[5]  = 2'd0; vm[5]  = 2'd3; vi[5]  = 1'b0; ve[5]  = 1'b0;
        vd[6]  = 4'b1000; vs[6]  = 2'd3; vm[6]  = 2'd0; vi[6]  = 1'b0; ve[6]  = 1'b1;
        vd[7]  = 4'b1000; vs[7]  = 2'd0; vm[7]  = 2'd0; vi[7]  = 1'b0; ve[7]  = 1'b0;
        vd[8]  = 4'b1111; vs[8]  = 2'd0; vm[8]  = 2'd1; vi[8]  = 1'b1; ve[8]  = 1'b0;
        vd[9]  = 4'b0000; vs[9]  = 2'd0; vm[9]  = 2'd2; vi[9]  = 1'b1; ve[9]  = 1'b1;
        vd[10] = 4'b0010; vs[10] = 2'd1; vm[10] = 2'd0; vi[10] = 1'b0; ve[10] = 1'b1;
        vd[11] = 4'b0010; vs[11] = 2'd1; vm[11] = 2'd0; vi[11] = 1'b1; ve[11] = 1'b0;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; in_mode = '0; in_inv = 1'b0;
        out_ready = 1'b0; exp_cur = 1'b0;
        in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; in_mode3 = '0; in_inv3 = 1'b0;
        out_ready3 = 1'b1; exp_cur3 = '0;
        step(); step();
        rst = 1'b0;

        // reset state
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_acc_cnt", int'(acc_cnt), 0);
        chk("rst_rej_cnt", int'(rej_cnt), 0);
        chk("rst_out_data", int'(out_data), 0);

        // modes on 4'b0110, each visible one cycle after accept
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: issue(4'b0110, 2'd2, 2'd0, 1'b0, 1'b1);
                1: issue(4'b0110, 2'd0, 2'd1, 1'b0, 1'b0);
                2: issue(4'b0110, 2'd0, 2'd2, 1'b0, 1'b1);
                3: issue(4'b0110, 2'd0, 2'd3, 1'b0, 1'b0);
                default: issue(4'b0110, 2'd0, 2'd3, 1'b1, 1'b1);
            endcase
            if (i == 0) chk("no_bypass", int'(out_valid), 0);
            step();
            in_valid = 1'b0;
            chk("mode_out_valid", int'(out_valid), 1);
            chk("mode_level", int'(level), 1);
            step();
            chk("mode_drained", int'(level), 0);
        end

        // fill with out_ready held low
        out_ready = 1'b0;
        issue(4'b1010, 2'd0, 2'd0, 1'b0, 1'b0); step();
        issue(4'b1010, 2'd1, 2'd0, 1'b0, 1'b1); step();
        issue(4'b1010, 2'd2, 2'd0, 1'b0, 1'b0); step();
        issue(4'b1010, 2'd3, 2'd0, 1'b0, 1'b1); step();
        chk("full_level", int'(level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        issue(4'b1111, 2'd0, 2'd1, 1'b0, 1'b1); step();
        chk("refused_level", int'(level), 4);
        chk("acc_cnt_9", int'(acc_cnt), 9);
`ifdef LSF_REJ_CNT_EN
        exp_rej = 1;
`else
        exp_rej = 0;
`endif
        chk("rej_cnt_fill", int'(rej_cnt), exp_rej);

        // full with simultaneous push and pop: only the pop happens
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fullpop_level", int'(level), 3);
        chk("fullpop_in_ready", int'(in_ready), 1);
        chk("fullpop_acc_cnt", int'(acc_cnt), 9);
`ifdef LSF_REJ_CNT_EN
        exp_rej = 2;
`endif
        chk("rej_cnt_fullpop", int'(rej_cnt), exp_rej);
        out_ready = 1'b1;
        step(); step(); step();
        chk("drain_level", int'(level), 0);

        // mid-level push+pop across pointer wraps
        out_ready = 1'b0;
        issue(vd[0], vs[0], vm[0], vi[0], ve[0]); step();
        issue(vd[1], vs[1], vm[1], vi[1], ve[1]); step();
        chk("mid_level_start", int'(level), 2);
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            issue(vd[i], vs[i], vm[i], vi[i], ve[i]);
            step();
            chk("mid_level_hold", int'(level), 2);
        end
        in_valid = 1'b0;
        step(); step();
        chk("mid_drain_level", int'(level), 0);

        // reset with three entries queued
        out_ready = 1'b0;
        issue(4'b1111, 2'd0, 2'd1, 1'b0, 1'b1); step();
        issue(4'b1111, 2'd0, 2'd1, 1'b0, 1'b1); step();
        issue(4'b1111, 2'd0, 2'd1, 1'b0, 1'b1); step();
        in_valid = 1'b0;
        chk("prerst_level", int'(level), 3);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        sb.delete();
        rst = 1'b0;
        chk("rst2_level", int'(level), 0);
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_acc_cnt", int'(acc_cnt), 0);
        chk("rst2_out_data", int'(out_data), 0);
        chk("rst2_rej_cnt", int'(rej_cnt), 0);

        // NUM_IN=3, WIDTH=2: {c,b,a}, out-of-range select and saturation
        issue3(6'b111111, 2'd3, 2'd0, 1'b0, 2'b00); step();
        issue3(6'b111111, 2'd3, 2'd0, 1'b1, 2'b11); step();
        issue3(6'b100111, 2'd2, 2'd0, 1'b0, 2'b10); step();
        issue3(6'b111101, 2'd0, 2'd1, 1'b0, 2'b01); step();
        issue3(6'b011011, 2'd0, 2'd3, 1'b1, 2'b11); step();
        in_valid3 = 1'b0;
        chk("sat_acc_cnt3", int'(acc_cnt3), 3);
        step(); step();
        chk("dut3_level", int'(level3), 0);

        chk("sb_empty", sb.size(), 0);
        chk("sb3_empty", sb3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
